// File: rtl/user_upd_reg.sv
// user_upd_reg: JTAG serial-in/parallel-out user DR; the shifted word goes to CLK via a toggle req/ack handshake.
// Latency: PO/PO_VLD change on the 3rd CLK edge after the UPDATE toggle (+1 for sync); BUSY clears 2 TCK after ack.
// Backpressure: an UPDATE while BUSY is dropped and flagged on sticky DROP; `USER_UPD_LEN_CHK_EN adds the bit-count check.
module user_upd_reg #(
  parameter int               width   = 8,
  parameter logic [width-1:0] PO_INIT = {width{1'b0}}
) (
  input  logic             RST,
  input  logic             TCK,
  input  logic             CLK,
  input  logic             DRCK_EN,
  input  logic             FSH,
  input  logic             FUPD,
  input  logic             SEL,
  input  logic             TDI,
  input  logic             SHIFT,
  input  logic             CAPTURE,
  input  logic             UPDATE,
  output logic             TDO,
  output logic             BUSY,
  output logic             LEN_ERR,
  output logic             DROP,
  output logic [width-1:0] PO,
  output logic             PO_VLD
);

  logic             en, ce_sh, ce_cap, ce_upd;
  logic [width-1:0] sr, hold;
  logic             req, as1, as2;
  logic             rs1, rs2, rs3;
  logic             drop_q, len_ok;

  assign en     = SEL & DRCK_EN;
  assign ce_sh  = en & (FSH | FUPD) & SHIFT;
  assign ce_cap = en & FUPD & CAPTURE;
  assign ce_upd = en & FUPD & UPDATE;

  assign TDO  = ce_sh & sr[0];
  assign BUSY = req ^ as2;
  assign DROP = drop_q;

`ifdef USER_UPD_LEN_CHK_EN
  localparam int             CW       = $clog2(width + 2);
  localparam logic [CW-1:0]  CNT_FULL = CW'(width);
  localparam logic [CW-1:0]  CNT_SAT  = CW'(width + 1);

  logic [CW-1:0] cnt;
  logic          len_err_q;

  // cnt saturates one past full so over-long shifts stay distinguishable
  always_ff @(posedge TCK or posedge RST) begin
    if (RST) begin
      cnt       <= '0;
      len_err_q <= 1'b0;
    end else if (ce_cap) begin
      cnt       <= '0;
      len_err_q <= 1'b0;
    end else if (ce_upd) begin
      if (!BUSY && cnt != CNT_FULL) len_err_q <= 1'b1;
    end else if (ce_sh && cnt != CNT_SAT) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign len_ok  = (cnt == CNT_FULL);
  assign LEN_ERR = len_err_q;
`else
  assign len_ok  = 1'b1;
  assign LEN_ERR = 1'b0;
`endif

  // hold only moves when not BUSY, so CLK always samples a quiet bus
  always_ff @(posedge TCK or posedge RST) begin
    if (RST) begin
      sr     <= '0;
      hold   <= PO_INIT;
      req    <= 1'b0;
      drop_q <= 1'b0;
      as1    <= 1'b0;
      as2    <= 1'b0;
    end else begin
      as1 <= rs2;
      as2 <= as1;
      if (ce_cap) begin
        drop_q <= 1'b0;
      end else if (ce_upd) begin
        if (BUSY) begin
          drop_q <= 1'b1;
        end else if (len_ok) begin
          hold <= sr;
          req  <= ~req;
        end
      end else if (ce_sh) begin
        sr <= {TDI, sr[width-1:1]};
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rs1    <= 1'b0;
      rs2    <= 1'b0;
      rs3    <= 1'b0;
      PO     <= PO_INIT;
      PO_VLD <= 1'b0;
    end else begin
      rs1    <= req;
      rs2    <= rs1;
      rs3    <= rs2;
      PO_VLD <= rs2 ^ rs3;
      if (rs2 ^ rs3) PO <= hold;
    end
  end

endmodule

// File: tb/tb_user_upd_reg.sv
// Bench for user_upd_reg: TAP-level stimulus in TCK, scoreboard of expected PO words checked on PO_VLD in CLK.
module tb_user_upd_reg;

  logic       RST, TCK, CLK, DRCK_EN, FSH, FUPD, SEL, TDI, SHIFT, CAPTURE, UPDATE;
  logic       TDO, BUSY, LEN_ERR, DROP, PO_VLD;
  logic [7:0] PO;

  user_upd_reg #(.width(8), .PO_INIT(8'h00)) dut (
    .RST(RST), .TCK(TCK), .CLK(CLK), .DRCK_EN(DRCK_EN), .FSH(FSH), .FUPD(FUPD),
    .SEL(SEL), .TDI(TDI), .SHIFT(SHIFT), .CAPTURE(CAPTURE), .UPDATE(UPDATE),
    .TDO(TDO), .BUSY(BUSY), .LEN_ERR(LEN_ERR), .DROP(DROP), .PO(PO), .PO_VLD(PO_VLD)
  );

  typedef struct { logic [7:0] dat; int cc; } exp_t;
  exp_t       sb[$];
  int         n_vec = 0, n_err = 0;
  int         clk_cnt = 0, upd_cc = 0, clk_half = 80;
  logic       tdo_s;
  logic [7:0] last_po = 8'h00;

  // CLK edges sit at odd offsets, never on a TCK edge or a sample point
  initial begin TCK = 1'b0; forever #50 TCK = ~TCK; end
  initial begin CLK = 1'b0; #3; forever begin #(clk_half); CLK = ~CLK; end end
  always @(posedge CLK) clk_cnt++;

  always @(negedge CLK) begin
    if (PO_VLD) begin
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_po_vld: PO=%h with no transfer pending", PO);
      end else begin
        exp_t e;
        int   lat;
        e = sb.pop_front();
        n_vec++;
        if (PO !== e.dat) begin
          n_err++; $display("FAIL po_data: got %h, expected %h", PO, e.dat);
        end
        lat = clk_cnt - e.cc;
        n_vec++;
        if (lat < 3 || lat > 4) begin
          n_err++; $display("FAIL po_latency: got %0d CLK, expected 3..4", lat);
        end
        last_po = e.dat;
      end
    end
  end

  task automatic tap(input logic cap, input logic upd, input logic sh, input logic tdi);
    @(negedge TCK);
    CAPTURE = cap; UPDATE = upd; SHIFT = sh; TDI = tdi;
    #10 tdo_s = TDO;
    @(posedge TCK);
    upd_cc = clk_cnt;
    #10;
  endtask

  task automatic shift_bits(input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++) tap(1'b0, 1'b0, 1'b1, d[i]);
  endtask

  task automatic push_exp(input logic [7:0] d);
    exp_t e;
    e.dat = d; e.cc = upd_cc;
    sb.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++; $display("FAIL %s: got %h, expected %h", nm, got, want);
    end
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    tap(1'b0, 1'b0, 1'b0, 1'b0);
    while ((sb.size() != 0 || BUSY) && k < 200) begin
      tap(1'b0, 1'b0, 1'b0, 1'b0);
      k++;
    end
    n_vec++;
    if (sb.size() != 0 || BUSY) begin
      n_err++; $display("FAIL %s_drain: pending=%0d BUSY=%b, expected 0 and 0", nm, sb.size(), BUSY);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tap(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    RST = 1'b1; SEL = 1'b1; DRCK_EN = 1'b1; FUPD = 1'b1; FSH = 1'b0;
    TDI = 1'b0; SHIFT = 1'b0; CAPTURE = 1'b0; UPDATE = 1'b0;
    repeat (4) @(posedge CLK);
    @(negedge TCK); RST = 1'b0;
    #10;
    chk("rst_tdo", {7'd0, TDO}, 8'h00);
    chk("rst_busy", {7'd0, BUSY}, 8'h00);
    chk("rst_len_err", {7'd0, LEN_ERR}, 8'h00);
    chk("rst_drop", {7'd0, DROP}, 8'h00);
    chk("rst_po", PO, 8'h00);
    chk("rst_po_vld", {7'd0, PO_VLD}, 8'h00);
  endtask

  task automatic transfer(input string nm, input logic [7:0] d);
    tap(1'b1, 1'b0, 1'b0, 1'b0);
    shift_bits({8'h00, d}, 8);
    tap(1'b0, 1'b1, 1'b0, 1'b0);
    push_exp(d);
    chk({nm, "_busy_hi"}, {7'd0, BUSY}, 8'h01);
    drain(nm);
    chk({nm, "_len_err"}, {7'd0, LEN_ERR}, 8'h00);
    chk({nm, "_po"}, PO, d);
  endtask

  task automatic test_length;
    logic [8:0] w9;
    w9 = 9'h169;
    tap(1'b1, 1'b0, 1'b0, 1'b0);
    shift_bits({7'd0, w9}, 9);
    tap(1'b0, 1'b1, 1'b0, 1'b0);
`ifdef USER_UPD_LEN_CHK_EN
    chk("len9_busy", {7'd0, BUSY}, 8'h00);
    idle(10);
    chk("len9_len_err", {7'd0, LEN_ERR}, 8'h01);
    chk("len9_po_kept", PO, last_po);
    tap(1'b1, 1'b0, 1'b0, 1'b0);
    chk("len_cap_clears", {7'd0, LEN_ERR}, 8'h00);
    tap(1'b0, 1'b1, 1'b0, 1'b0);
    idle(10);
    chk("len0_len_err", {7'd0, LEN_ERR}, 8'h01);
    chk("len0_po_kept", PO, last_po);
`else
    push_exp(w9[8:1]);
    drain("len9");
    chk("len9_len_err", {7'd0, LEN_ERR}, 8'h00);
    chk("len9_po", PO, w9[8:1]);
    tap(1'b1, 1'b0, 1'b0, 1'b0);
    tap(1'b0, 1'b1, 1'b0, 1'b0);
    push_exp(w9[8:1]);
    drain("len0");
    chk("len0_len_err", {7'd0, LEN_ERR}, 8'h00);
`endif
  endtask

  task automatic test_back_to_back;
    clk_half = 400;
    tap(1'b1, 1'b0, 1'b0, 1'b0);
    shift_bits(16'h00C3, 8);
    tap(1'b0, 1'b1, 1'b0, 1'b0);
    push_exp(8'hC3);
    tap(1'b0, 1'b1, 1'b0, 1'b0);
    tap(1'b0, 1'b0, 1'b0, 1'b0);
    chk("b2b_drop", {7'd0, DROP}, 8'h01);
    drain("b2b");
    chk("b2b_po", PO, 8'hC3);
    tap(1'b1, 1'b0, 1'b0, 1'b0);
    chk("b2b_cap_clears_drop", {7'd0, DROP}, 8'h00);
    clk_half = 80;
  endtask

  task automatic test_fsh_only;
    logic [15:0] d;
    d = 16'($urandom);
    FSH = 1'b1; FUPD = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tap(1'b0, 1'b0, 1'b1, d[i]);
      if (i >= 8) chk("fsh_tdo", {7'd0, tdo_s}, {7'd0, d[i-8]});
    end
    tap(1'b0, 1'b1, 1'b0, 1'b0);
    chk("fsh_busy", {7'd0, BUSY}, 8'h00);
    idle(10);
    chk("fsh_po_kept", PO, last_po);
    chk("fsh_flags", {6'd0, LEN_ERR, DROP}, 8'h00);
    FSH = 1'b0; FUPD = 1'b1;
  endtask

  task automatic test_reset_mid;
    tap(1'b1, 1'b0, 1'b0, 1'b0);
    shift_bits(16'h0077, 8);
    tap(1'b0, 1'b1, 1'b0, 1'b0);
    tap(1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid_busy_before_rst", {7'd0, BUSY}, 8'h01);
    RST = 1'b1;
    last_po = 8'h00;
    repeat (3) @(posedge CLK);
    #5 RST = 1'b0;
    idle(12);
    chk("mid_po", PO, 8'h00);
    chk("mid_po_vld", {7'd0, PO_VLD}, 8'h00);
    chk("mid_busy", {7'd0, BUSY}, 8'h00);
    transfer("after_rst", 8'h3C);
  endtask

  task automatic test_gating;
    SEL = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tap(1'b0, 1'b0, 1'b1, 1'b1);
      chk("gate_sel_tdo", {7'd0, tdo_s}, 8'h00);
    end
    tap(1'b1, 1'b0, 1'b0, 1'b0);
    tap(1'b0, 1'b1, 1'b0, 1'b0);
    chk("gate_sel_busy", {7'd0, BUSY}, 8'h00);
    SEL = 1'b1; DRCK_EN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tap(1'b0, 1'b0, 1'b1, 1'b1);
      chk("gate_drck_tdo", {7'd0, tdo_s}, 8'h00);
    end
    tap(1'b0, 1'b1, 1'b0, 1'b0);
    chk("gate_drck_busy", {7'd0, BUSY}, 8'h00);
    DRCK_EN = 1'b1;
    // an enabled UPDATE now must still deliver the untouched word
    tap(1'b0, 1'b1, 1'b0, 1'b0);
    push_exp(8'h3C);
    drain("gate");
    chk("gate_flags", {6'd0, LEN_ERR, DROP}, 8'h00);
  endtask

  initial begin
    test_reset;
    transfer("a5", 8'hA5);
    test_length;
    test_back_to_back;
    test_fsh_only;
    test_reset_mid;
    test_gating;
    idle(10);
    chk("sb_empty", 8'(sb.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
